fpga_piano: RTL and testbench

//  Eight-key FPGA piano: sw[7:0] select C4..C5, FREQ drives a speaker with a square wave.

---
 rtl/fpga_piano.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_fpga_piano.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpga_piano.sv
// Eight-key piano: square-wave tone, guided and autoplay songs, 4-digit multiplexed display.
// Optional build macro PIANO_SCORE_EN adds the miss counter and the two-digit score readout.
module fpga_piano #(
  parameter int unsigned CLK_HZ        = 100_000_000,
  parameter int unsigned NOTE_TICKS    = 25_000_000,
  parameter int unsigned REFRESH_TICKS = 100_000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       ODETOJOY,
  input  logic       ODETOJOY_AUTO,
  input  logic       DOREMI,
  input  logic       DOREMI_AUTO,
  input  logic [7:0] sw,
  output logic       FREQ,
  output logic [7:0] Led,
  output logic [7:0] seg,
  output logic [3:0] an
);

  localparam int unsigned HalfC4    = CLK_HZ / 524;
  localparam int unsigned TW        = (HalfC4 > 2) ? $clog2(HalfC4) : 1;
  localparam int unsigned NW        = (NOTE_TICKS > 2) ? $clog2(NOTE_TICKS) : 1;
  localparam int unsigned RW        = (REFRESH_TICKS > 2) ? $clog2(REFRESH_TICKS) : 1;
  localparam int unsigned ToneTicks = NOTE_TICKS * 3 / 4;

  // One nibble per note, first note in the most significant nibble, zero padded to 64.
  localparam logic [255:0] OdeRom =
    256'h5543_3456_7765_5665_5433_4567_7656_7700_0000_0000_0000_0000_0000_0000_0000_0000;
  localparam logic [255:0] DrmRom =
    256'h7657_5756_5445_6454_3535_3432_2342_3765_4322_6543_2115_4321_0012_4130_3560_0000;
  localparam logic [5:0] OdeLen = 6'd30;
  localparam logic [5:0] DrmLen = 6'd59;

  typedef enum logic [2:0] {
    ModeFree, ModeOde, ModeOdeAuto, ModeDrm, ModeDrmAuto
  } mode_e;

  function automatic logic [2:0] rom_at(input logic [255:0] tbl, input logic [5:0] i);
    logic [2:0] r;
    r = '0;
    for (int k = 0; k < 64; k++) begin
      if (i == 6'(k)) r = tbl[4*(63-k) +: 3];
    end
    return r;
  endfunction

  function automatic logic [TW-1:0] half_m1(input logic [2:0] k);
    int unsigned f;
    int unsigned h;
    case (k)
      3'd7:    f = 262;
      3'd6:    f = 294;
      3'd5:    f = 330;
      3'd4:    f = 349;
      3'd3:    f = 392;
      3'd2:    f = 440;
      3'd1:    f = 494;
      default: f = 523;
    endcase
    h = CLK_HZ / (2 * f);
    if (h == 0) h = 1;
    return TW'(h - 1);
  endfunction

  function automatic logic [7:0] letter_glyph(input logic [2:0] k);
    case (k)
      3'd6:    return 8'hA1; // d
      3'd5:    return 8'h86; // E
      3'd4:    return 8'h8E; // F
      3'd3:    return 8'hC2; // G
      3'd2:    return 8'h88; // A
      3'd1:    return 8'h83; // b
      default: return 8'hC6; // C (C4 and C5)
    endcase
  endfunction

  logic [11:0]   meta_q, sync_q;
  logic [7:0]    keys, keys_prev_q, edges, note_oh;
  mode_e         mode_req, mode_q, mode_d;
  logic [5:0]    idx_q, idx_d, song_len;
  logic [NW-1:0] tick_q, tick_d;
  logic [2:0]    note, tone_key, tkey_q;
  logic          tone_on, ton_q, freq_q, freq_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [1:0]    dig_q, dig_d;
  logic [3:0]    an_q, an_d;
  logic [7:0]    seg_q, seg_d, mode_glyph, digit2, digit3;
  logic          ode_sel, auto_mode, guided, done, last;

  assign keys      = sync_q[7:0];
  assign edges     = keys & ~keys_prev_q;
  assign ode_sel   = (mode_q == ModeOde) || (mode_q == ModeOdeAuto);
  assign auto_mode = (mode_q == ModeOdeAuto) || (mode_q == ModeDrmAuto);
  assign guided    = (mode_q == ModeOde) || (mode_q == ModeDrm);
  assign song_len  = ode_sel ? OdeLen : DrmLen;
  assign note      = rom_at(ode_sel ? OdeRom : DrmRom, idx_q);
  assign note_oh   = 8'b1 << note;
  assign done      = guided && (idx_q == song_len);
  assign last      = idx_q == (song_len - 6'd1);

  always_comb begin
    if (sync_q[11])      mode_req = ModeOdeAuto;
    else if (sync_q[10]) mode_req = ModeDrmAuto;
    else if (sync_q[9])  mode_req = ModeOde;
    else if (sync_q[8])  mode_req = ModeDrm;
    else                 mode_req = ModeFree;
  end

`ifdef PIANO_SCORE_EN
  logic [6:0] miss_q, miss_d, score;
  logic [3:0] tens, ones;

  function automatic logic [7:0] digit_glyph(input logic [3:0] d);
    case (d)
      4'd0:    return 8'hC0;
      4'd1:    return 8'hF9;
      4'd2:    return 8'hA4;
      4'd3:    return 8'hB0;
      4'd4:    return 8'h99;
      4'd5:    return 8'h92;
      4'd6:    return 8'h82;
      4'd7:    return 8'hF8;
      4'd8:    return 8'h80;
      default: return 8'h90;
    endcase
  endfunction

  assign score  = auto_mode ? {1'b0, idx_q} : miss_q;
  assign tens   = 4'(score / 7'd10);
  assign ones   = 4'(score % 7'd10);
  assign digit3 = (mode_q == ModeFree) ? 8'hFF : digit_glyph(tens);
  assign digit2 = (mode_q == ModeFree) ? 8'hFF : digit_glyph(ones);
`else
  assign digit3 = 8'hFF;
  assign digit2 = 8'hFF;
`endif

  // Song sequencing; a mode change pre-empts any key edge seen in the same cycle.
  always_comb begin
    mode_d = mode_q;
    idx_d  = idx_q;
    tick_d = tick_q;
`ifdef PIANO_SCORE_EN
    miss_d = miss_q;
`endif
    if (mode_req != mode_q) begin
      mode_d = mode_req;
      idx_d  = '0;
      tick_d = '0;
`ifdef PIANO_SCORE_EN
      miss_d = '0;
`endif
    end else begin
      unique case (mode_q)
        ModeOde, ModeDrm: begin
          if (!done) begin
            if ((edges & note_oh) != 8'h00) idx_d = idx_q + 6'd1;
`ifdef PIANO_SCORE_EN
            if ((edges & ~note_oh) != 8'h00 && miss_q != 7'd99) miss_d = miss_q + 7'd1;
`endif
          end
        end
        ModeOdeAuto, ModeDrmAuto: begin
          if (tick_q == NW'(NOTE_TICKS - 1)) begin
            tick_d = '0;
            idx_d  = last ? 6'd0 : idx_q + 6'd1;
          end else begin
            tick_d = tick_q + NW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    tone_on  = 1'b0;
    tone_key = 3'd0;
    if (auto_mode) begin
      tone_on  = tick_q < NW'(ToneTicks);
      tone_key = note;
    end else begin
      tone_on = |keys;
      for (int i = 0; i < 8; i++) begin
        if (keys[i]) tone_key = 3'(i);
      end
    end
  end

  always_comb begin
    tcnt_d = tcnt_q + TW'(1);
    freq_d = freq_q;
    if (!tone_on || !ton_q || (tone_key != tkey_q)) begin
      tcnt_d = '0;
      freq_d = 1'b0;
    end else if (tcnt_q == half_m1(tone_key)) begin
      tcnt_d = '0;
      freq_d = ~freq_q;
    end
  end

  always_comb begin
    unique case (mode_q)
      ModeOde:     mode_glyph = 8'hC0; // O
      ModeOdeAuto: mode_glyph = 8'hA3; // o
      ModeDrm:     mode_glyph = 8'hA1; // d
      ModeDrmAuto: mode_glyph = 8'hC0; // D
      default:     mode_glyph = 8'h8E; // F
    endcase
  end

  always_comb begin
    rcnt_d = rcnt_q + RW'(1);
    dig_d  = dig_q;
    if (rcnt_q == RW'(REFRESH_TICKS - 1)) begin
      rcnt_d = '0;
      dig_d  = dig_q + 2'd1;
    end
    an_d = ~(4'b0001 << dig_q);
    unique case (dig_q)
      2'd0:    seg_d = tone_on ? letter_glyph(tone_key) : 8'hBF;
      2'd1:    seg_d = mode_glyph;
      2'd2:    seg_d = digit2;
      default: seg_d = digit3;
    endcase
  end

  always_comb begin
    if (auto_mode)   Led = note_oh;
    else if (done)   Led = 8'hFF;
    else if (guided) Led = note_oh;
    else             Led = keys;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      meta_q      <= '0;
      sync_q      <= '0;
      keys_prev_q <= '0;
      mode_q      <= ModeFree;
      idx_q       <= '0;
      tick_q      <= '0;
      tkey_q      <= '0;
      ton_q       <= 1'b0;
      tcnt_q      <= '0;
      freq_q      <= 1'b0;
      rcnt_q      <= '0;
      dig_q       <= '0;
      an_q        <= 4'hF;
      seg_q       <= 8'hFF;
`ifdef PIANO_SCORE_EN
      miss_q      <= '0;
`endif
    end else begin
      meta_q      <= {ODETOJOY_AUTO, DOREMI_AUTO, ODETOJOY, DOREMI, sw};
      sync_q      <= meta_q;
      keys_prev_q <= keys;
      mode_q      <= mode_d;
      idx_q       <= idx_d;
      tick_q      <= tick_d;
      tkey_q      <= tone_key;
      ton_q       <= tone_on;
      tcnt_q      <= tcnt_d;
      freq_q      <= freq_d;
      rcnt_q      <= rcnt_d;
      dig_q       <= dig_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
`ifdef PIANO_SCORE_EN
      miss_q      <= miss_d;
`endif
    end
  end

  assign FREQ = freq_q;
  assign seg  = seg_q;
  assign an   = an_q;

endmodule

// File: tb/tb_fpga_piano.sv
// Self-checking bench for fpga_piano: table vectors, hand sequences and a random guided-play model.
module tb_fpga_piano;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       ODETOJOY = 1'b0, ODETOJOY_AUTO = 1'b0, DOREMI = 1'b0, DOREMI_AUTO = 1'b0;
  logic [7:0] sw = 8'h00;
  logic       FREQ;
  logic [7:0] Led, seg;
  logic [3:0] an;

  fpga_piano #(
    .CLK_HZ       (5240),
    .NOTE_TICKS   (40),
    .REFRESH_TICKS(4)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .ODETOJOY     (ODETOJOY),
    .ODETOJOY_AUTO(ODETOJOY_AUTO),
    .DOREMI       (DOREMI),
    .DOREMI_AUTO  (DOREMI_AUTO),
    .sw           (sw),
    .FREQ         (FREQ),
    .Led          (Led),
    .seg          (seg),
    .an           (an)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] sw;
    logic [7:0] led;
    int         key;
  } free_vec_t;

  typedef struct {
    logic       oa, da, o, d;
    logic [7:0] glyph;
    logic [7:0] led;
  } mode_vec_t;

  int ode_song [30] = '{5,5,4,3,3,4,5,6,7,7,6,5,5,6,6,5,5,4,3,3,4,5,6,7,7,6,5,6,7,7};
  int drm_song [59] = '{7,6,5,7,5,7,5, 6,5,4,4,5,6,4, 5,4,3,5,3,5,3, 4,3,2,2,3,4,2,
                        3,7,6,5,4,3,2, 2,6,5,4,3,2,1, 1,5,4,3,2,1,0, 0,1,2,4,1,3,0, 3,5,6};
  int freq_hz [8] = '{523, 494, 440, 392, 349, 330, 294, 262};
  logic [7:0] letter [8] = '{8'hC6, 8'h83, 8'h88, 8'hC2, 8'h8E, 8'h86, 8'hA1, 8'hC6};
  logic [7:0] digits [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                              8'h80, 8'h90};

  free_vec_t fv [9];
  mode_vec_t mv [9];
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  function automatic int half_of(input int k);
    return 5240 / (2 * freq_hz[k]);
  endfunction

  task automatic press(input int k);
    sw = 8'(1 << k);
    step(4);
    sw = 8'h00;
    step(4);
  endtask

  task automatic read_digit(input string name, input logic [3:0] sel, output logic [7:0] s);
    bit found;
    found = 1'b0;
    s = 8'h00;
    for (int i = 0; i < 16 && !found; i++) begin
      @(negedge CLK);
      if (an == sel) begin
        found = 1'b1;
        s = seg;
      end
    end
    check({name, "_scan"}, 32'(found), 32'd1);
  endtask

  task automatic measure(output int hi, output int lo);
    int n;
    hi = 0;
    lo = 0;
    n = 0;
    while (FREQ !== 1'b0 && n < 60) begin step(1); n++; end
    while (FREQ !== 1'b1 && n < 120) begin step(1); n++; end
    while (FREQ === 1'b1 && hi < 60) begin step(1); hi++; end
    while (FREQ === 1'b0 && lo < 60) begin step(1); lo++; end
  endtask

  task automatic set_modes(input logic oa, input logic da, input logic o, input logic d);
    ODETOJOY_AUTO = oa;
    DOREMI_AUTO   = da;
    ODETOJOY      = o;
    DOREMI        = d;
  endtask

  task automatic check_score(input string name, input int val);
    logic [7:0] s;
`ifdef PIANO_SCORE_EN
    read_digit({name, "_ones"}, 4'b1011, s);
    check({name, "_ones"}, 32'(s), 32'(digits[val % 10]));
    read_digit({name, "_tens"}, 4'b0111, s);
    check({name, "_tens"}, 32'(s), 32'(digits[val / 10]));
`else
    read_digit({name, "_blank"}, 4'b1011, s);
    check({name, "_blank"}, 32'(s), 32'hFF);
`endif
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] s;
    int hi, lo, idx, miss, k, cnt;
    bit seen, found;

    fv[0] = '{8'h80, 8'h80, 7};
    fv[1] = '{8'h81, 8'h81, 7};
    fv[2] = '{8'h00, 8'h00, -1};
    fv[3] = '{8'h40, 8'h40, 6};
    fv[4] = '{8'h01, 8'h01, 0};
    fv[5] = '{8'h10, 8'h10, 4};
    fv[6] = '{8'hFF, 8'hFF, 7};
    fv[7] = '{8'h03, 8'h03, 1};
    fv[8] = '{8'h24, 8'h24, 5};

    mv[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h8E, 8'h00};
    mv[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'hC0, 8'h20};
    mv[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'hA3, 8'h20};
    mv[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'hA1, 8'h80};
    mv[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'hC0, 8'h80};
    mv[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'hA3, 8'h20};
    mv[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'hC0, 8'h80};
    mv[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'hC0, 8'h20};
    mv[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'hC0, 8'h80};

    // Reset state
    step(3);
    check("reset_freq", 32'(FREQ), 32'd0);
    check("reset_led", 32'(Led), 32'h00);
    check("reset_an", 32'(an), 32'hF);
    check("reset_seg", 32'(seg), 32'hFF);
    RESET = 1'b1;
    step(3);
    check("scan_one_low", 32'($countones(~an)), 32'd1);

    // Free play table
    for (int i = 0; i < 9; i++) begin
      sw = fv[i].sw;
      step(6);
      check($sformatf("free%0d_led", i), 32'(Led), 32'(fv[i].led));
      read_digit($sformatf("free%0d_note", i), 4'b1110, s);
      if (fv[i].key < 0) begin
        check($sformatf("free%0d_glyph", i), 32'(s), 32'hBF);
        cnt = 0;
        for (int c = 0; c < 40; c++) begin step(1); if (FREQ) cnt++; end
        check($sformatf("free%0d_silent", i), 32'(cnt), 32'd0);
      end else begin
        check($sformatf("free%0d_glyph", i), 32'(s), 32'(letter[fv[i].key]));
        measure(hi, lo);
        check($sformatf("free%0d_high", i), 32'(hi), 32'(half_of(fv[i].key)));
        check($sformatf("free%0d_low", i), 32'(lo), 32'(half_of(fv[i].key)));
      end
    end
    sw = 8'h00;
    step(4);
    read_digit("free_score", 4'b0111, s);
    check("free_score_blank", 32'(s), 32'hFF);

    // Mode priority table
    for (int i = 0; i < 9; i++) begin
      set_modes(1'b0, 1'b0, 1'b0, 1'b0);
      step(6);
      set_modes(mv[i].oa, mv[i].da, mv[i].o, mv[i].d);
      step(5);
      check($sformatf("mode%0d_led", i), 32'(Led), 32'(mv[i].led));
      read_digit($sformatf("mode%0d", i), 4'b1101, s);
      check($sformatf("mode%0d_glyph", i), 32'(s), 32'(mv[i].glyph));
    end

    // Guided Ode to Joy with one miss
    set_modes(1'b0, 1'b0, 1'b0, 1'b0);
    step(6);
    ODETOJOY = 1'b1;
    step(6);
    check("ode_start_led", 32'(Led), 32'h20);
    press(5);
    press(5);
    check("ode_idx2_led", 32'(Led), 32'h10);
    press(7);
    check("ode_miss_led", 32'(Led), 32'h10);
    check_score("ode_miss", 1);
    for (int i = 2; i < 30; i++) begin
      press(ode_song[i]);
      check($sformatf("ode_step%0d", i + 1), 32'(Led),
            (i + 1 < 30) ? 32'(1 << ode_song[i + 1]) : 32'hFF);
    end
    press(5);
    check("ode_done_hold", 32'(Led), 32'hFF);

    // Reset mid-song
    RESET = 1'b0;
    #1;
    check("midreset_led", 32'(Led), 32'h00);
    check("midreset_an", 32'(an), 32'hF);
    check("midreset_seg", 32'(seg), 32'hFF);
    check("midreset_freq", 32'(FREQ), 32'd0);
    step(2);
    RESET = 1'b1;
    step(6);
    check("midreset_restart", 32'(Led), 32'h20);
    check_score("midreset", 0);

    // Mode change and key edge in the same cycle: edge is dropped
    ODETOJOY = 1'b0;
    DOREMI = 1'b1;
    sw = 8'h80;
    step(6);
    check("simul_led", 32'(Led), 32'h80);
    sw = 8'h00;
    step(4);
    press(7);
    check("simul_after_press", 32'(Led), 32'h40);

    // Random guided Do-Re-Mi against the song model
    set_modes(1'b0, 1'b0, 1'b0, 1'b0);
    step(6);
    DOREMI = 1'b1;
    step(6);
    idx = 0;
    miss = 0;
    for (int n = 0; n < 140; n++) begin
      if (idx < 59 && $urandom_range(0, 3) != 0) k = drm_song[idx];
      else k = int'($urandom_range(0, 7));
      press(k);
      if (idx < 59) begin
        if (k == drm_song[idx]) idx++;
        else if (miss < 99) miss++;
      end
      check($sformatf("rand%0d_led", n), 32'(Led), (idx == 59) ? 32'hFF : 32'(1 << drm_song[idx]));
    end
    check_score("rand", miss);

    // Autoplay Ode to Joy, keys ignored, wraps after 30 notes
    set_modes(1'b0, 1'b0, 1'b0, 1'b0);
    sw = 8'h00;
    step(6);
    ODETOJOY_AUTO = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      step(1);
      if (Led != 8'h00) found = 1'b1;
    end
    check("auto_start_found", 32'(found), 32'd1);
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step(1);
      if (FREQ) seen = 1'b1;
      sw = 8'($urandom);
    end
    check("auto_tone_on", 32'(seen), 32'd1);
    for (int n = 0; n < 62; n++) begin
      check($sformatf("auto_note%0d", n), 32'(Led), 32'(1 << ode_song[n % 30]));
      if (n < 4) begin
        step(15);
        check($sformatf("auto_rest%0d", n), 32'(FREQ), 32'd0);
        step(25);
      end else begin
        step(40);
      end
      sw = 8'($urandom);
    end

    // Do-Re-Mi autoplay, then switch to guided mid-song
    sw = 8'h00;
    set_modes(1'b0, 1'b0, 1'b0, 1'b0);
    step(6);
    DOREMI_AUTO = 1'b1;
    step(100);
    check("drm_auto_mid", 32'(Led), 32'(1 << drm_song[2]));
    DOREMI_AUTO = 1'b0;
    DOREMI = 1'b1;
    step(6);
    check("drm_guided_start", 32'(Led), 32'h80);
    press(7);
    check("drm_guided_idx1", 32'(Led), 32'(1 << drm_song[1]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
